// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan driver.
//   SEG_LUT  - hex nibble to active-low segment pattern {g,f,e,d,c,b,a}
//   SEG_OFF  - all segments dark
//   COM_OFF  - all digit commons disabled
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] COM_OFF = 8'hFF;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: count input and display pin bundle of the scan driver.
//   value/load/dp_mask      - count and decimal points from the counter stage
//   seg/dp/segcom           - active-low display pins
//   digit_idx/frame_done    - scan position and end-of-frame pulse
//   master: counter stage side; slave: scan driver side.
interface seg7_scan_driver_if;

    logic [31:0] value;
    logic        load;
    logic [7:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  segcom;
    logic [2:0]  digit_idx;
    logic        frame_done;

    modport master (
        output value, load, dp_mask,
        input  seg, dp, segcom, digit_idx, frame_done
    );

    modport slave (
        input  value, load, dp_mask,
        output seg, dp, segcom, digit_idx, frame_done
    );

endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to active-low segment pattern.
//   nibble_i  in  4  hex digit
//   seg_o     out 7  segments {g,f,e,d,c,b,a}, 0 = lit
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes a 32-bit count onto an 8-digit common-anode
// 7-segment display (hex per nibble, digit 0 = value[3:0]) with tear-free frame
// updates, leading-zero blanking and anti-ghost dead time after each digit switch.
//   clk    in  1  system clock
//   reset  in  1  synchronous, active-high
//   bus    slave modport: value/load/dp_mask in; seg/dp/segcom/digit_idx/frame_done out
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned SCAN_HZ   = 1_000,
    parameter int unsigned BLANK_CYC = 4,
    parameter int unsigned BLANK_LZ  = 1
) (
    input  logic              clk,
    input  logic              reset,
    seg7_scan_driver_if.slave bus
);

    localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DW  = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [DW-1:0] dead_q, dead_d;
    logic [31:0]   pend_q, pend_d;
    logic [31:0]   shad_q, shad_d;
    logic [7:0]    pdp_q, pdp_d;
    logic [7:0]    sdp_q, sdp_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [7:0]    com_q, com_d;
    logic          fd_q, fd_d;

    logic          tick;
    logic          boundary;
    logic [3:0]    nib;
    logic [6:0]    nib_seg;
    logic [7:0]    lz_blank;
    logic          zero_above;

    assign tick     = (presc_q == PW'(DIV - 1));
    assign boundary = tick && (idx_q == 3'd7);
    assign nib      = shad_q[{idx_q, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .nibble_i (nib),
        .seg_o    (nib_seg)
    );

    // Digit k is blank when it and every more significant nibble are zero.
    always_comb begin
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int unsigned k = 7; k >= 1; k--) begin
            zero_above  = zero_above && (shad_q[4*k +: 4] == 4'h0);
            lz_blank[k] = (BLANK_LZ != 0) && zero_above;
        end
    end

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        dead_d  = dead_q;
        pend_d  = pend_q;
        shad_d  = shad_q;
        pdp_d   = pdp_q;
        sdp_d   = sdp_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        com_d   = com_q;
        fd_d    = 1'b0;

        if (bus.load) begin
            pend_d = bus.value;
            pdp_d  = bus.dp_mask;
        end

        // A load on the boundary edge bypasses pending so the new value is not lost.
        if (boundary) begin
            shad_d = bus.load ? bus.value   : pend_q;
            sdp_d  = bus.load ? bus.dp_mask : pdp_q;
            fd_d   = 1'b1;
        end

        // The enable and segment data switch on the same edge (the one that ends the
        // dead time), so a digit is never lit with the previous digit's pattern.
        if (tick) begin
            idx_d  = idx_q + 3'd1;
            com_d  = COM_OFF;
            dead_d = DW'(BLANK_CYC);
        end else if ((dead_q != '0) && (dead_q != DW'(1))) begin
            dead_d = dead_q - DW'(1);
            com_d  = COM_OFF;
        end else begin
            dead_d = '0;
            com_d  = ~(8'd1 << idx_q);
            seg_d  = lz_blank[idx_q] ? SEG_OFF : nib_seg;
            dp_d   = ~sdp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            dead_q  <= DW'(BLANK_CYC);
            pend_q  <= '0;
            shad_q  <= '0;
            pdp_q   <= '0;
            sdp_q   <= '0;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            com_q   <= COM_OFF;
            fd_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            dead_q  <= dead_d;
            pend_q  <= pend_d;
            shad_q  <= shad_d;
            pdp_q   <= pdp_d;
            sdp_q   <= sdp_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            com_q   <= com_d;
            fd_q    <= fd_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.segcom     = com_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int unsigned DIV   = 10;
    localparam int unsigned BLANK = 2;
    localparam int unsigned FRAME = 8 * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] value = '0;
    logic        load = 1'b0;
    logic [7:0]  dp_mask = '0;

    int errors = 0;
    int checks = 0;

    // reference model state
    int unsigned m_n = 0;
    logic [31:0] m_pend = '0, m_shown = '0;
    logic [7:0]  m_pdp = '0, m_sdp = '0;
    logic [6:0]  m_seg = 7'h7F, m_seg_nlz = 7'h7F;
    logic        m_dp = 1'b1, m_fd = 1'b0;
    logic [7:0]  m_com = 8'hFF;
    logic [2:0]  m_digit = '0;

    always #5 clk = ~clk;

    seg7_scan_driver_if ifa ();
    seg7_scan_driver_if ifb ();

    assign ifa.value = value;   assign ifb.value = value;
    assign ifa.load = load;     assign ifb.load = load;
    assign ifa.dp_mask = dp_mask; assign ifb.dp_mask = dp_mask;

    seg7_scan_driver #(.CLK_HZ(100), .SCAN_HZ(10), .BLANK_CYC(2), .BLANK_LZ(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    seg7_scan_driver #(.CLK_HZ(100), .SCAN_HZ(10), .BLANK_CYC(2), .BLANK_LZ(0)) dut_nlz (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    // One clock: update the model from time since reset release, then stop at negedge.
    task automatic cycle();
        logic [31:0] upper;
        int unsigned p;
        @(posedge clk);
        if (reset) begin
            m_n = 0; m_pend = '0; m_shown = '0; m_pdp = '0; m_sdp = '0;
            m_seg = 7'h7F; m_seg_nlz = 7'h7F; m_dp = 1'b1; m_com = 8'hFF;
            m_fd = 1'b0; m_digit = '0;
        end else begin
            m_n++;
            m_fd = (m_n % FRAME == 0);
            if (m_fd) begin
                m_shown = load ? value : m_pend;
                m_sdp   = load ? dp_mask : m_pdp;
            end
            if (load) begin
                m_pend = value;
                m_pdp  = dp_mask;
            end
            m_digit = 3'((m_n / DIV) % 8);
            p = m_n % DIV;
            if (p >= BLANK) begin
                m_com     = ~(8'd1 << m_digit);
                upper     = m_shown >> (4 * m_digit);
                m_seg_nlz = glyph(upper[3:0]);
                m_seg     = (m_digit != 0 && upper == 0) ? 7'h7F : m_seg_nlz;
                m_dp      = ~m_sdp[m_digit];
            end else begin
                m_com = 8'hFF;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit found = 0;
        reset = 1'b1;
        repeat (5) begin
            cycle();
            checks++;
            if (ifa.seg !== 7'h7F || ifa.dp !== 1'b1 || ifa.segcom !== 8'hFF || ifa.frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: seg=%h dp=%b com=%h fd=%b, want 7f 1 ff 0",
                         ifa.seg, ifa.dp, ifa.segcom, ifa.frame_done);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (ifa.segcom === 8'hFE) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_release: com=%h, want fe within 3 cycles", ifa.segcom);
        end
        checks++;
        if (ifa.seg !== 7'h40 || ifa.dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_zero: seg=%h dp=%b, want 40 1", ifa.seg, ifa.dp);
        end
    endtask

    task automatic test_load_mid_frame();
        int lit [8];
        int dark = 0;
        int guard = 0;
        bit seen = 0;
        while (m_digit != 3'd3 && guard < 100) begin cycle(); guard++; end
        value = 32'h1234_5678; dp_mask = 8'($urandom); load = 1'b1;
        cycle();
        load = 1'b0;
        foreach (lit[i]) lit[i] = 0;
        for (int c = 0; c < 200; c++) begin
            checks++;
            if (ifa.segcom !== m_com || ifa.seg !== m_seg || ifa.dp !== m_dp ||
                ifa.frame_done !== m_fd || ifa.digit_idx !== m_digit) begin
                errors++;
                $display("FAIL mid_frame n=%0d: com=%h seg=%h dp=%b fd=%b idx=%0d, want %h %h %b %b %0d",
                         m_n, ifa.segcom, ifa.seg, ifa.dp, ifa.frame_done, ifa.digit_idx,
                         m_com, m_seg, m_dp, m_fd, m_digit);
            end
            if (ifa.frame_done === 1'b1) seen = 1;
            if (seen) begin
                if (ifa.segcom === 8'hFF) dark++;
                else lit[ifa.digit_idx]++;
                if (ifa.segcom === 8'hFE) begin
                    checks++;
                    if (ifa.seg !== 7'h00) begin
                        errors++;
                        $display("FAIL mid_frame_d0: seg=%h, want 00", ifa.seg);
                    end
                end
                if (ifa.segcom === 8'h7F) begin
                    checks++;
                    if (ifa.seg !== 7'h79) begin
                        errors++;
                        $display("FAIL mid_frame_d7: seg=%h, want 79", ifa.seg);
                    end
                    if (lit[7] == 8) break;
                end
            end
            cycle();
        end
        checks++;
        if (!seen || dark != 16 || lit[0] != 8 || lit[3] != 8 || lit[7] != 8) begin
            errors++;
            $display("FAIL mid_frame_duty: seen=%0d dark=%0d lit0=%0d lit3=%0d lit7=%0d, want 1 16 8 8 8",
                     seen, dark, lit[0], lit[3], lit[7]);
        end
    endtask

    task automatic test_lz();
        int guard = 0;
        cycle();
        value = 32'h0000_00A5; dp_mask = 8'($urandom); load = 1'b1;
        cycle();
        load = 1'b0;
        while (m_fd !== 1'b1 && guard < 200) begin cycle(); guard++; end
        checks++;
        if (ifa.frame_done !== 1'b1) begin
            errors++;
            $display("FAIL lz_wait: frame_done=%b, want 1 within budget", ifa.frame_done);
        end
        repeat (FRAME) begin
            checks++;
            if (ifa.segcom !== m_com || ifa.seg !== m_seg || ifa.dp !== m_dp ||
                ifb.segcom !== m_com || ifb.seg !== m_seg_nlz || ifb.dp !== m_dp) begin
                errors++;
                $display("FAIL lz_model n=%0d: com=%h seg=%h/%h dp=%b/%b, want %h %h/%h %b",
                         m_n, ifa.segcom, ifa.seg, ifb.seg, ifa.dp, ifb.dp, m_com, m_seg, m_seg_nlz, m_dp);
            end
            if (ifa.segcom !== 8'hFF) begin
                checks++;
                if ((ifa.digit_idx == 3'd0 && ifa.seg !== 7'h12) ||
                    (ifa.digit_idx == 3'd1 && ifa.seg !== 7'h08) ||
                    (ifa.digit_idx >= 3'd2 && (ifa.seg !== 7'h7F || ifb.seg !== 7'h40))) begin
                    errors++;
                    $display("FAIL lz_digit%0d: seg=%h nlz_seg=%h", ifa.digit_idx, ifa.seg, ifb.seg);
                end
            end
            cycle();
        end
    endtask

    task automatic test_load_on_boundary();
        int guard = 0;
        cycle();
        value = 32'h0000_0012; load = 1'b1;
        cycle();
        load = 1'b0;
        while ((m_n % FRAME) != FRAME - 1 && guard < 200) begin cycle(); guard++; end
        value = 32'hFFFF_FFFF; dp_mask = 8'($urandom); load = 1'b1;
        cycle();
        load = 1'b0;
        checks++;
        if (ifa.frame_done !== 1'b1) begin
            errors++;
            $display("FAIL boundary_fd: frame_done=%b, want 1", ifa.frame_done);
        end
        repeat (FRAME) begin
            checks++;
            if (ifa.segcom !== m_com || ifa.seg !== m_seg || ifa.dp !== m_dp || ifa.digit_idx !== m_digit) begin
                errors++;
                $display("FAIL boundary_model n=%0d: com=%h seg=%h dp=%b idx=%0d, want %h %h %b %0d",
                         m_n, ifa.segcom, ifa.seg, ifa.dp, ifa.digit_idx, m_com, m_seg, m_dp, m_digit);
            end
            if (ifa.segcom !== 8'hFF) begin
                checks++;
                if (ifa.seg !== 7'h0E) begin
                    errors++;
                    $display("FAIL boundary_F digit%0d: seg=%h, want 0e", ifa.digit_idx, ifa.seg);
                end
            end
            cycle();
        end
    endtask

    task automatic test_frame_timing();
        int last_fd = -1;
        int npulse = 0;
        logic [6:0] prev_seg = ifa.seg;
        logic [7:0] prev_com = ifa.segcom;
        logic prev_fd = ifa.frame_done;
        for (int c = 0; c < 2 * FRAME + 20; c++) begin
            if (c % 23 == 5) begin value = $urandom; dp_mask = 8'($urandom); load = 1'b1; end
            cycle();
            load = 1'b0;
            checks++;
            if (ifa.frame_done !== m_fd || $countones(~ifa.segcom) > 1 ||
                (ifa.seg !== prev_seg && prev_com !== 8'hFF) ||
                (prev_fd === 1'b1 && ifa.frame_done === 1'b1)) begin
                errors++;
                $display("FAIL timing n=%0d: fd=%b(prev %b) com=%h prev_com=%h seg=%h prev_seg=%h",
                         m_n, ifa.frame_done, prev_fd, ifa.segcom, prev_com, ifa.seg, prev_seg);
            end
            if (ifa.frame_done === 1'b1) begin
                if (last_fd >= 0) begin
                    checks++;
                    if (c - last_fd != FRAME) begin
                        errors++;
                        $display("FAIL fd_period: got %0d, want %0d", c - last_fd, FRAME);
                    end
                end
                last_fd = c;
                npulse++;
            end
            prev_seg = ifa.seg; prev_com = ifa.segcom; prev_fd = ifa.frame_done;
        end
        checks++;
        if (npulse < 2) begin
            errors++;
            $display("FAIL fd_count: got %0d pulses, want >= 2", npulse);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            value = $urandom >> (4 * $urandom_range(0, 8));
            dp_mask = 8'($urandom);
            load = 1'b1;
            cycle();
            load = 1'b0;
            repeat ($urandom_range(1, 90)) begin
                checks++;
                if (ifa.segcom !== m_com || ifa.seg !== m_seg || ifa.dp !== m_dp ||
                    ifa.frame_done !== m_fd || ifa.digit_idx !== m_digit ||
                    ifb.segcom !== m_com || ifb.seg !== m_seg_nlz || ifb.dp !== m_dp) begin
                    errors++;
                    $display("FAIL random n=%0d: com=%h seg=%h/%h dp=%b fd=%b idx=%0d, want %h %h/%h %b %b %0d",
                             m_n, ifa.segcom, ifa.seg, ifb.seg, ifa.dp, ifa.frame_done, ifa.digit_idx,
                             m_com, m_seg, m_seg_nlz, m_dp, m_fd, m_digit);
                end
                cycle();
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int guard = 0;
        bit found = 0;
        value = 32'h8765_4321; load = 1'b1;
        cycle();
        load = 1'b0;
        while (!(m_digit == 3'd5 && m_com != 8'hFF) && guard < 200) begin cycle(); guard++; end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++;
        if (ifa.segcom !== 8'hFF || ifa.digit_idx !== 3'd0 || ifa.seg !== 7'h7F || ifa.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: com=%h idx=%0d seg=%h fd=%b, want ff 0 7f 0",
                     ifa.segcom, ifa.digit_idx, ifa.seg, ifa.frame_done);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (ifa.segcom === 8'hFE) begin found = 1; break; end
        end
        checks++;
        if (!found || ifa.seg !== 7'h40 || ifb.seg !== 7'h40) begin
            errors++;
            $display("FAIL reset_mid_d0: found=%0d seg=%h nlz=%h, want 1 40 40", found, ifa.seg, ifb.seg);
        end
        guard = 0;
        while (ifa.segcom !== 8'hFD && guard < 20) begin cycle(); guard++; end
        checks++;
        if (ifa.segcom !== 8'hFD || ifa.seg !== 7'h7F || ifb.seg !== 7'h40) begin
            errors++;
            $display("FAIL reset_mid_d1: com=%h seg=%h nlz=%h, want fd 7f 40", ifa.segcom, ifa.seg, ifb.seg);
        end
    endtask

    initial begin
        test_reset();
        test_load_mid_frame();
        test_lz();
        test_load_on_boundary();
        test_frame_timing();
        test_random();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
